// File: rtl/wb_clint_pkg.sv
// Shared constants and helpers for the Wishbone CLINT: register offsets,
// the mtimecmp reset value and the byte-lane merge used by every write.
package wb_clint_pkg;

    localparam logic [31:0] OFF_MSIP        = 32'h0000_0000;
    localparam logic [31:0] OFF_MTIME_LO    = 32'h0000_0008;
    localparam logic [31:0] OFF_MTIME_HI    = 32'h0000_000C;
    localparam logic [31:0] OFF_MTIMECMP_LO = 32'h0000_0010;
    localparam logic [31:0] OFF_MTIMECMP_HI = 32'h0000_0014;

    localparam logic [63:0] MTIMECMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_MTIME_LO,
        REG_MTIME_HI,
        REG_CMP_LO,
        REG_CMP_HI
    } reg_sel_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_mtime.sv
// Free-running prescaler plus the 64-bit mtime counter. A bus load of either
// word wins over a coincident tick; the prescaler keeps counting regardless.
module clint_mtime #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic [31:0] load_data,
    output logic        tick,
    output logic [63:0] mtime
);

    localparam logic [15:0] LAST_COUNT = 16'(PRESCALE - 1);

    logic [15:0] count;

    assign tick = (count == LAST_COUNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

    // The full 64-bit add gives the low-to-high carry in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= '0;
        end else if (load_lo || load_hi) begin
            if (load_lo) mtime[31:0]  <= load_data;
            if (load_hi) mtime[63:32] <= load_data;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: rtl/wb_clint.sv
// Wishbone classic slave exposing MSIP, mtime and mtimecmp, and driving the
// registered timer and software interrupt lines of one hart.
module wb_clint
    import wb_clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0000,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned PRESCALE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wbs_addr,
    input  logic [31:0] wbs_dat_w,
    input  logic [3:0]  wbs_sel,
    input  logic        wbs_we,
    input  logic        wbs_cyc,
    input  logic        wbs_stb,
    input  logic [2:0]  wbs_cti,
    input  logic [1:0]  wbs_bte,
    output logic [31:0] wbs_dat_r,
    output logic        wbs_ack,
    output logic        wbs_err,
    output logic        timer_interrupt,
    output logic        software_interrupt
);

    localparam logic [31:0] OFF_MASK = 32'((64'd1 << ADDR_WIDTH) - 64'd1);

    logic [31:0] offset;
    logic        in_window;
    reg_sel_e    reg_sel;
    logic        resp_prev;
    logic        req;
    logic        hit;
    logic        wr;
    logic [31:0] rd_data;
    logic [31:0] wr_base;
    logic [31:0] wr_data;
    logic        msip;
    logic [63:0] mtimecmp;
    logic [63:0] mtime;
    logic        tick;
    logic        load_lo;
    logic        load_hi;
    logic        unused_bus;

    // Burst hints are irrelevant: every access is handled as a classic cycle.
    assign unused_bus = ^{wbs_cti, wbs_bte, tick};

    assign offset    = wbs_addr & OFF_MASK;
    assign in_window = ((wbs_addr & ~OFF_MASK) == (BASE_ADDR & ~OFF_MASK));

    always_comb begin
        reg_sel = REG_NONE;
        if (in_window && (wbs_addr[1:0] == 2'b00)) begin
            case (offset)
                OFF_MSIP:        reg_sel = REG_MSIP;
                OFF_MTIME_LO:    reg_sel = REG_MTIME_LO;
                OFF_MTIME_HI:    reg_sel = REG_MTIME_HI;
                OFF_MTIMECMP_LO: reg_sel = REG_CMP_LO;
                OFF_MTIMECMP_HI: reg_sel = REG_CMP_HI;
                default:         reg_sel = REG_NONE;
            endcase
        end
    end

    // A new request is only taken once the bus has been quiet for a full cycle.
    assign req = wbs_cyc && wbs_stb && !wbs_ack && !wbs_err && !resp_prev;
    assign hit = req && (reg_sel != REG_NONE);
    assign wr  = hit && wbs_we;

    always_comb begin
        rd_data = '0;
        wr_base = '0;
        case (reg_sel)
            REG_MSIP:     begin rd_data = {31'd0, msip};    wr_base = {31'd0, msip};    end
            REG_MTIME_LO: begin rd_data = mtime[31:0];      wr_base = mtime[31:0];      end
            REG_MTIME_HI: begin rd_data = mtime[63:32];     wr_base = mtime[63:32];     end
            REG_CMP_LO:   begin rd_data = mtimecmp[31:0];   wr_base = mtimecmp[31:0];   end
            REG_CMP_HI:   begin rd_data = mtimecmp[63:32];  wr_base = mtimecmp[63:32];  end
            default:      begin rd_data = '0;               wr_base = '0;               end
        endcase
    end

    assign wr_data = merge_bytes(wr_base, wbs_dat_w, wbs_sel);
    assign load_lo = wr && (reg_sel == REG_MTIME_LO);
    assign load_hi = wr && (reg_sel == REG_MTIME_HI);

    clint_mtime #(
        .PRESCALE (PRESCALE)
    ) u_mtime (
        .clk       (clk),
        .rst       (rst),
        .load_lo   (load_lo),
        .load_hi   (load_hi),
        .load_data (wr_data),
        .tick      (tick),
        .mtime     (mtime)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wbs_ack            <= 1'b0;
            wbs_err            <= 1'b0;
            wbs_dat_r          <= '0;
            resp_prev          <= 1'b0;
            msip               <= 1'b0;
            mtimecmp           <= MTIMECMP_RESET;
            timer_interrupt    <= 1'b0;
            software_interrupt <= 1'b0;
        end else begin
            wbs_ack            <= hit;
            wbs_err            <= req && !hit;
            wbs_dat_r          <= (hit && !wbs_we) ? rd_data : 32'd0;
            resp_prev          <= wbs_ack || wbs_err;
            timer_interrupt    <= (mtime >= mtimecmp);
            software_interrupt <= msip;
            if (wr && reg_sel == REG_MSIP)   msip            <= wr_data[0];
            if (wr && reg_sel == REG_CMP_LO) mtimecmp[31:0]  <= wr_data;
            if (wr && reg_sel == REG_CMP_HI) mtimecmp[63:32] <= wr_data;
        end
    end

endmodule
